// File: rtl/tt_prog_loader.sv
// Program loader for the tiny accumulator core: receives a header/data/checksum
// byte stream, writes it into the instruction memory and gates core_run.
module tt_prog_loader #(
  parameter int          DEPTH   = 16,
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     core_run,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_err,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   addr;
  logic [3:0]      rem;
  logic [7:0]      sum;
  logic [23:0]     tmo_cnt;
  logic            prog_valid;
  logic            xfer;
  logic [7:0]      chk_total;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready is registered and high exactly while the FSM is in HDR/DATA/CHK.
  assign xfer      = in_valid && in_ready;
  assign chk_total = sum + in_data;
  assign rd_data   = mem[rd_addr];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      load_busy  <= 1'b0;
      core_run   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      prog_valid <= 1'b0;
      addr       <= '0;
      rem        <= '0;
      sum        <= '0;
      tmo_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      load_done <= 1'b0;
      if (state == S_IDLE) begin
        if (load_start) begin
          state      <= S_HDR;
          in_ready   <= 1'b1;
          load_busy  <= 1'b1;
          core_run   <= 1'b0;
          load_err   <= 1'b0;
          prog_valid <= 1'b0;
          tmo_cnt    <= '0;
        end
      end else if (xfer) begin
        tmo_cnt <= '0;
        if (state == S_HDR) begin
          addr  <= in_data[4 +: AW];
          rem   <= in_data[3:0];
          sum   <= in_data;
          state <= S_DATA;
        end else if (state == S_DATA) begin
          mem[addr] <= in_data;
          addr      <= addr + 1'b1;
          sum       <= chk_total;
          if (rem == 4'd0) state <= S_CHK;
          else             rem   <= rem - 4'd1;
        end else begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          load_busy <= 1'b0;
          if (chk_total == 8'h00) begin
            prog_valid <= 1'b1;
            core_run   <= 1'b1;
            load_done  <= 1'b1;
          end else begin
            load_err <= 1'b1;
          end
        end
      end else if (tmo_cnt == TIMEOUT - 24'd1) begin
        // Stalled stream: abandon the load, keeping whatever was already written.
        state     <= S_IDLE;
        in_ready  <= 1'b0;
        load_busy <= 1'b0;
        load_err  <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 24'd1;
      end
    end
  end

endmodule
